tmds_decoder_dvi_align: RTL and testbench

TMDS_DECODER_DVI_ALIGN -- requirements
Module: tmds_decoder_dvi_align

---
 rtl/tmds_decoder_dvi_align.sv | 262 ++++++++++++++++++++++++++
 tb/tb_tmds_decoder_dvi_align.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_decoder_dvi_align.sv
// ---------------------------------------------------------------------------
// tmds_decoder_dvi_align
//
// Word aligner and TMDS decoder for one DVI channel.
//
// The deserializer delivers 10-bit words whose boundary is arbitrary after
// power-up. This block looks for long runs of TMDS control tokens, which
// only occur in properly framed blanking periods. If no run shows up within
// the timeout, it asks the deserializer to rotate its word boundary by one
// bit, lets the deserializer settle, and searches again. Once a full run of
// tokens has been seen, the channel is declared aligned. After that, control
// tokens and video data words are decoded into o_ctrl / o_data / o_de.
// Lock is dropped if no full token run shows up within the timeout.
//
// Parameters
//   LOCK_COUNT : consecutive control tokens needed to declare alignment
//   TIMEOUT    : cycles without a completed token run before a slip
//                (while searching) or loss of lock (while locked)
//   SLIP_WAIT  : settle cycles after a bitslip request (must be >= 1)
//
// Ports
//   i_clk       : pixel clock, the only clock
//   i_rst_n     : asynchronous active-low reset, release synchronised here
//   i_tmds      : parallel word from the deserializer, bit 0 first on wire
//   o_bitslip   : one-cycle request to rotate the deserializer boundary
//   o_aligned   : high while the channel is locked
//   o_de        : decoded word is video data
//   o_data      : decoded pixel data
//   o_ctrl      : decoded control bits {ctrl1, ctrl0}
//   o_lock_lost : one-cycle pulse when lock is dropped
// ---------------------------------------------------------------------------
module tmds_decoder_dvi_align #(
  parameter int LOCK_COUNT = 64,
  parameter int TIMEOUT    = 1024,
  parameter int SLIP_WAIT  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [9:0] i_tmds,
  output logic       o_bitslip,
  output logic       o_aligned,
  output logic       o_de,
  output logic [7:0] o_data,
  output logic [1:0] o_ctrl,
  output logic       o_lock_lost
);

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [RUN_W-1:0]  RUN_FULL  = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  // Reset release synchroniser
  logic [1:0] rstSync_q;
  logic       coreEn;

  // State and counters
  state_e            state_q, state_d;
  logic [RUN_W-1:0]  runCnt_q, runCnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;

  // Registered outputs
  logic       bitslip_q, bitslip_d;
  logic       aligned_q, aligned_d;
  logic       lockLost_q, lockLost_d;
  logic       de_q, de_d;
  logic [7:0] data_q, data_d;
  logic [1:0] ctrl_q, ctrl_d;

  // Word classification and decode
  logic             isToken;
  logic [1:0]       tokenCtrl;
  logic [7:0]       dataWord;
  logic [7:0]       decoded;
  logic [RUN_W-1:0] runNext;
  logic             runDone;
  logic [TMR_W-1:0] timerInc;

  // Reset assertion is immediate; release walks through two flops so the
  // core never leaves reset on a clock edge that races the deassertion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rstSync_q <= 2'b00;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b1};
    end
  end

  assign coreEn = rstSync_q[1];

  // The four TMDS control tokens; anything else is treated as video data.
  always_comb begin
    isToken   = 1'b1;
    tokenCtrl = 2'b00;
    case (i_tmds)
      10'b1101010100: tokenCtrl = 2'b00;
      10'b0010101011: tokenCtrl = 2'b01;
      10'b0101010100: tokenCtrl = 2'b10;
      10'b1010101011: tokenCtrl = 2'b11;
      default:        isToken   = 1'b0;
    endcase
  end

  // TMDS data decode: undo the optional inversion (bit 9), then undo the
  // XOR / XNOR transition chain selected by bit 8.
  always_comb begin
    dataWord   = i_tmds[9] ? ~i_tmds[7:0] : i_tmds[7:0];
    decoded    = 8'h00;
    decoded[0] = dataWord[0];
    for (int i = 1; i < 8; i++) begin
      decoded[i] = i_tmds[8] ? (dataWord[i] ^ dataWord[i-1])
                             : ~(dataWord[i] ^ dataWord[i-1]);
    end
  end

  // Run counter candidate: saturating count of consecutive tokens. A
  // "completed run" is any cycle in which the count sits at LOCK_COUNT, so a
  // blanking period longer than LOCK_COUNT keeps refreshing the timer.
  always_comb begin
    if (!isToken) begin
      runNext = '0;
    end else if (runCnt_q == RUN_FULL) begin
      runNext = RUN_FULL;
    end else begin
      runNext = runCnt_q + RUN_ONE;
    end
    runDone  = (runNext == RUN_FULL);
    timerInc = (timer_q == TMR_LAST) ? timer_q : timer_q + TMR_ONE;
  end

  // Next-state logic for the alignment FSM plus the next values of all
  // registered outputs. Nothing advances until the reset release has passed
  // through the synchroniser. Decode outputs follow the next state so they
  // are valid exactly while o_aligned is high.
  always_comb begin
    state_d    = state_q;
    runCnt_d   = runCnt_q;
    timer_d    = timer_q;
    waitCnt_d  = waitCnt_q;
    bitslip_d  = 1'b0;
    aligned_d  = 1'b0;
    lockLost_d = 1'b0;
    de_d       = 1'b0;
    data_d     = 8'h00;
    ctrl_d     = 2'b00;

    if (coreEn) begin
      case (state_q)
        ST_SEARCH: begin
          runCnt_d = runNext;
          timer_d  = runDone ? '0 : timerInc;
          // A completed run takes priority over an expiring timer.
          if (runDone) begin
            state_d = ST_LOCKED;
          end else if (timer_q == TMR_LAST) begin
            state_d  = ST_SLIP;
            runCnt_d = '0;
            timer_d  = '0;
          end
        end

        ST_SLIP: begin
          state_d   = ST_WAIT;
          runCnt_d  = '0;
          timer_d   = '0;
          waitCnt_d = '0;
        end

        ST_WAIT: begin
          runCnt_d = '0;
          timer_d  = '0;
          if (waitCnt_q == WAIT_LAST) begin
            state_d   = ST_SEARCH;
            waitCnt_d = '0;
          end else begin
            waitCnt_d = waitCnt_q + WAIT_ONE;
          end
        end

        ST_LOCKED: begin
          runCnt_d = runNext;
          timer_d  = runDone ? '0 : timerInc;
          if (!runDone && (timer_q == TMR_LAST)) begin
            state_d  = ST_SEARCH;
            runCnt_d = '0;
            timer_d  = '0;
          end
        end

        default: begin
          state_d  = ST_SEARCH;
          runCnt_d = '0;
          timer_d  = '0;
        end
      endcase
    end

    bitslip_d  = (state_d == ST_SLIP);
    aligned_d  = (state_d == ST_LOCKED);
    lockLost_d = (state_q == ST_LOCKED) && (state_d == ST_SEARCH);

    if (state_d == ST_LOCKED) begin
      if (isToken) begin
        ctrl_d = tokenCtrl;
      end else begin
        de_d   = 1'b1;
        data_d = decoded;
        ctrl_d = ctrl_q;
      end
    end
  end

  // State, counters and output registers. Reset clears everything at once,
  // which also cancels any pulse that was in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_SEARCH;
      runCnt_q   <= '0;
      timer_q    <= '0;
      waitCnt_q  <= '0;
      bitslip_q  <= 1'b0;
      aligned_q  <= 1'b0;
      lockLost_q <= 1'b0;
      de_q       <= 1'b0;
      data_q     <= 8'h00;
      ctrl_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      runCnt_q   <= runCnt_d;
      timer_q    <= timer_d;
      waitCnt_q  <= waitCnt_d;
      bitslip_q  <= bitslip_d;
      aligned_q  <= aligned_d;
      lockLost_q <= lockLost_d;
      de_q       <= de_d;
      data_q     <= data_d;
      ctrl_q     <= ctrl_d;
    end
  end

  assign o_bitslip   = bitslip_q;
  assign o_aligned   = aligned_q;
  assign o_lock_lost = lockLost_q;
  assign o_de        = de_q;
  assign o_data      = data_q;
  assign o_ctrl      = ctrl_q;

endmodule

// File: tb/tb_tmds_decoder_dvi_align.sv
// ---------------------------------------------------------------------------
// tb_tmds_decoder_dvi_align
//
// Self-checking bench for tmds_decoder_dvi_align with default parameters.
// A behavioural model of the aligner runs alongside the DUT and is compared
// on every falling clock edge; directed scenarios add hand-computed checks.
// ---------------------------------------------------------------------------
module tb_tmds_decoder_dvi_align;

  localparam int LOCK_COUNT = 64;
  localparam int TIMEOUT    = 1024;
  localparam int SLIP_WAIT  = 4;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;
  localparam logic [9:0] DATA0 = 10'b0100000000;
  localparam logic [9:0] DATAF = 10'b1011111111;

  logic       clk = 1'b0;
  logic       rstN = 1'b1;
  logic [9:0] tmds = 10'd0;
  logic       oBitslip, oAligned, oDe, oLockLost;
  logic [7:0] oData;
  logic [1:0] oCtrl;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit cmpEn = 1'b0;

  tmds_decoder_dvi_align #(
    .LOCK_COUNT(LOCK_COUNT),
    .TIMEOUT(TIMEOUT),
    .SLIP_WAIT(SLIP_WAIT)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rstN),
    .i_tmds(tmds),
    .o_bitslip(oBitslip),
    .o_aligned(oAligned),
    .o_de(oDe),
    .o_data(oData),
    .o_ctrl(oCtrl),
    .o_lock_lost(oLockLost)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  typedef enum {M_SEARCH, M_SLIP, M_WAIT, M_LOCKED} mphase_t;
  mphase_t    mPhase = M_SEARCH;
  int         mRun = 0;
  int         mSince = 0;
  int         mWaitLeft = 0;
  int         mRel = 0;
  logic       eBitslip = 1'b0, eAligned = 1'b0, eLockLost = 1'b0, eDe = 1'b0;
  logic [7:0] eData = 8'h00;
  logic [1:0] eCtrl = 2'b00;

  function automatic int tokenOf(input logic [9:0] w);
    case (w)
      10'b1101010100: return 0;
      10'b0010101011: return 1;
      10'b0101010100: return 2;
      10'b1010101011: return 3;
      default:        return -1;
    endcase
  endfunction

  function automatic logic [7:0] decodeData(input logic [9:0] w);
    logic [7:0] d;
    logic [7:0] o;
    d = w[9] ? ~w[7:0] : w[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = w[8] ? (d[i] ^ d[i-1]) : !(d[i] ^ d[i-1]);
    return o;
  endfunction

  function automatic logic [9:0] rot10(input logic [9:0] w, input int off);
    logic [19:0] dd;
    dd = {w, w};
    return dd[off +: 10];
  endfunction

  always @(posedge clk or negedge rstN) begin
    int      tok;
    bit      hit;
    mphase_t nxt;
    if (!rstN) begin
      mPhase = M_SEARCH; mRun = 0; mSince = 0; mWaitLeft = 0; mRel = 0;
      eBitslip = 0; eAligned = 0; eLockLost = 0; eDe = 0; eData = 0; eCtrl = 0;
    end else begin
      if (mRel >= 2) begin
        tok = tokenOf(tmds);
        nxt = mPhase;
        case (mPhase)
          M_SEARCH, M_LOCKED: begin
            mRun = (tok >= 0) ? ((mRun < LOCK_COUNT) ? mRun + 1 : LOCK_COUNT) : 0;
            hit  = (mRun == LOCK_COUNT);
            if (mPhase == M_SEARCH) begin
              if (hit) nxt = M_LOCKED;
              else if (mSince == TIMEOUT - 1) nxt = M_SLIP;
            end else if (!hit && mSince == TIMEOUT - 1) begin
              nxt = M_SEARCH;
            end
            mSince = hit ? 0 : mSince + 1;
            if (nxt == M_SLIP || (mPhase == M_LOCKED && nxt == M_SEARCH)) begin
              mRun = 0; mSince = 0;
            end
          end
          M_SLIP: begin
            nxt = M_WAIT;
            mWaitLeft = SLIP_WAIT;
          end
          default: begin
            mWaitLeft = mWaitLeft - 1;
            if (mWaitLeft == 0) begin
              nxt = M_SEARCH; mRun = 0; mSince = 0;
            end
          end
        endcase
        eBitslip  = (nxt == M_SLIP);
        eAligned  = (nxt == M_LOCKED);
        eLockLost = (mPhase == M_LOCKED && nxt == M_SEARCH);
        if (nxt == M_LOCKED) begin
          if (tok >= 0) begin
            eDe = 0; eData = 0; eCtrl = 2'(tok);
          end else begin
            eDe = 1; eData = decodeData(tmds);
          end
        end else begin
          eDe = 0; eData = 0; eCtrl = 0;
        end
        mPhase = nxt;
      end
      if (mRel < 2) mRel = mRel + 1;
    end
  end

  // ---------------- checking ----------------
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("cmp_bitslip",   32'(oBitslip),  32'(eBitslip));
      checkOutput("cmp_aligned",   32'(oAligned),  32'(eAligned));
      checkOutput("cmp_lock_lost", 32'(oLockLost), 32'(eLockLost));
      checkOutput("cmp_de",        32'(oDe),       32'(eDe));
      checkOutput("cmp_data",      32'(oData),     32'(eData));
      checkOutput("cmp_ctrl",      32'(oCtrl),     32'(eCtrl));
    end
  end

  // Drives one word per cycle for n cycles; returns just after the edge that
  // sampled the last word, so its result is visible on the outputs.
  task automatic applyStimulus(input logic [9:0] word, input int n);
    repeat (n) begin
      @(negedge clk);
      tmds = word;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_bitslip"},   32'(oBitslip),  0);
    checkOutput({tag, "_aligned"},   32'(oAligned),  0);
    checkOutput({tag, "_lock_lost"}, 32'(oLockLost), 0);
    checkOutput({tag, "_de"},        32'(oDe),       0);
    checkOutput({tag, "_data"},      32'(oData),     0);
    checkOutput({tag, "_ctrl"},      32'(oCtrl),     0);
  endtask

  task automatic releaseReset();
    repeat (2) @(negedge clk);
    rstN = 1'b1;
  endtask

  // Feeds data words for n cycles and reports whether a bitslip appeared.
  task automatic dataNoSlip(input int n, output bit saw);
    saw = 0;
    for (int i = 0; i < n; i++) begin
      applyStimulus(DATA0, 1);
      if (oBitslip) saw = 1;
    end
  endtask

  task automatic waitSlip(input int bound, output bit seen);
    seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      applyStimulus(DATA0, 1);
      if (oBitslip) seen = 1;
    end
  endtask

  initial begin
    #10_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit saw;
    bit seen;
    int off;
    int slips;
    int lastSlip;
    int afterSeventh;
    bit locked;

    #2 rstN = 1'b0;
    #1 cmpEn = 1'b1;
    checkAllZero("reset_state");

    // Aligned blanking stream, then a data word
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(TOK00, 200);
    checkOutput("aligned_after_200_tokens", 32'(oAligned), 1);
    applyStimulus(DATA0, 1);
    checkOutput("data00_de", 32'(oDe), 1);
    checkOutput("data00_value", 32'(oData), 32'h00);

    // Data and token decoding while locked
    applyStimulus(DATAF, 1);
    checkOutput("dataFE_value", 32'(oData), 32'hFE);
    checkOutput("dataFE_de", 32'(oDe), 1);
    applyStimulus(TOK11, 1);
    checkOutput("tok11_de", 32'(oDe), 0);
    checkOutput("tok11_ctrl", 32'(oCtrl), 32'h3);
    applyStimulus(DATA0, 1);
    checkOutput("ctrl_hold_on_data", 32'(oCtrl), 32'h3);

    // Loss of lock after TIMEOUT cycles of data
    applyStimulus(TOK00, 64);
    applyStimulus(DATA0, 1023);
    checkOutput("still_locked_1023", 32'(oAligned), 1);
    checkOutput("no_loss_1023", 32'(oLockLost), 0);
    applyStimulus(DATA0, 1);
    checkOutput("lock_lost_pulse", 32'(oLockLost), 1);
    checkOutput("lock_lost_aligned", 32'(oAligned), 0);
    checkOutput("lock_lost_de", 32'(oDe), 0);
    applyStimulus(DATA0, 1);
    checkOutput("lock_lost_single", 32'(oLockLost), 0);

    // Exactly LOCK_COUNT tokens are needed from a fresh search
    applyStimulus(TOK00, 63);
    checkOutput("not_aligned_63", 32'(oAligned), 0);
    checkOutput("outside_lock_ctrl", 32'(oCtrl), 0);
    applyStimulus(TOK00, 1);
    checkOutput("aligned_64", 32'(oAligned), 1);

    // Run completes on the same cycle the search timer expires
    applyStimulus(DATA0, 1024);
    checkOutput("loss_before_race", 32'(oLockLost), 1);
    applyStimulus(DATA0, 960);
    applyStimulus(TOK00, 63);
    checkOutput("race_pre_aligned", 32'(oAligned), 0);
    applyStimulus(TOK00, 1);
    checkOutput("race_aligned", 32'(oAligned), 1);
    checkOutput("race_no_bitslip", 32'(oBitslip), 0);

    // Rotated stream: deserializer model follows bitslip requests
    applyStimulus(DATA0, 1024);
    off = 3; slips = 0; lastSlip = -1; afterSeventh = 0; locked = 0;
    for (int c = 0; c < 9000 && !locked; c++) begin
      @(negedge clk);
      tmds = rot10(TOK00, off);
      @(posedge clk);
      #1;
      if (oBitslip) begin
        if (lastSlip >= 0) checkOutput("slip_period", 32'(cyc - lastSlip), 1029);
        lastSlip = cyc;
        slips++;
        off = (off + 1) % 10;
      end else if (slips >= 7) begin
        afterSeventh++;
      end
      if (oAligned) locked = 1;
    end
    checkOutput("slip_count", 32'(slips), 7);
    checkOutput("locked_after_rotations", 32'(locked), 1);
    checkOutput("lock_within_1024", 32'(afterSeventh < 1024), 1);

    // Reset while locked drops everything immediately, no loss pulse
    applyStimulus(DATAF, 1);
    checkOutput("pre_reset_de", 32'(oDe), 1);
    #2 rstN = 1'b0;
    #1 checkAllZero("reset_locked");
    releaseReset();

    // Reset in the middle of the SLIP cycle
    dataNoSlip(1024, saw);
    checkOutput("no_early_slip_1", 32'(saw), 0);
    waitSlip(10, seen);
    checkOutput("slip_seen_1", 32'(seen), 1);
    #1 rstN = 1'b0;
    #1 checkOutput("reset_slip_bitslip", 32'(oBitslip), 0);
    releaseReset();

    // Reset while waiting for the deserializer to settle
    dataNoSlip(1024, saw);
    checkOutput("no_early_slip_2", 32'(saw), 0);
    waitSlip(10, seen);
    checkOutput("slip_seen_2", 32'(seen), 1);
    applyStimulus(DATA0, 2);
    #2 rstN = 1'b0;
    #1 checkAllZero("reset_wait");
    releaseReset();
    dataNoSlip(1024, saw);
    checkOutput("no_early_slip_3", 32'(saw), 0);
    waitSlip(10, seen);
    checkOutput("slip_seen_3", 32'(seen), 1);

    @(negedge clk);
    cmpEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
